if_id_pipe_ctrl: RTL and testbench
==================================

# if_id_pipe_ctrl

Fetch-side consumer of the hazard unit's `Stall` and `Flush` controls in the 5-stage MIPS pipeline. Owns the program counter and the IF/ID pipeline register, and applies hazard decisions to them each cycle:
- **hold** on a load-use stall;
- **squash and redirect** on a taken branch;
- **advance** otherwise.

It also reports its control state for debug and, optionally, hazard statistics.

## Interface
- `RESET_PC`, default `32'h0040_0000`: PC value after reset (MIPS text base).
- `NOP_INSTR`, default `32'h0000_0000`: bubble instruction written into IF/ID on squash/reset.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-high; one clock domain.
- `Stall` in, 1: 1 = hold PC and IF/ID this cycle.
- `Flush` in, 1: active-low; 0 = branch taken, squash IF/ID and redirect PC.
- `BranchTarget` in, 32: redirect address, sampled when `Flush`=0.
- `Instruction` in, 32: instruction memory read data for the current `PC` (combinational read).
- `PC` out, 32: current fetch address to instruction memory.
- `IF_ID_Instruction` out, 32: registered instruction for decode.
- `IF_ID_PCPlus4` out, 32: registered PC+4 of that instruction.
- `IF_ID_Valid` out, 1: 1 = IF/ID holds a real instruction; 0 = bubble.
- `CtrlState` out, 2: `0` RUN, `1` HOLD, `2` SQUASH (state entered at last edge).
- `StallCycles` out, 32: stall cycle count (see Configuration).
- `FlushCount` out, 32: squash event count (see Configuration).

## Operation
- Per-edge action is chosen by priority: `Flush`=0 first, then `Stall`=1, then advance.
- **SQUASH** (`Flush`=0, regardless of `Stall`):
  - `PC` <= {`BranchTarget[31:2]`, 2'b00};
  - `IF_ID_Instruction` <= `NOP_INSTR`;
  - `IF_ID_PCPlus4` <= 0;
  - `IF_ID_Valid` <= 0;
  - `CtrlState` <= 2.
- **HOLD** (`Flush`=1, `Stall`=1): `PC` and all IF_ID_* outputs keep their values; `CtrlState` <= 1.
- **RUN** (`Flush`=1, `Stall`=0):
  - `IF_ID_Instruction` <= `Instruction`;
  - `IF_ID_PCPlus4` <= `PC`+4;
  - `IF_ID_Valid` <= 1;
  - `PC` <= `PC`+4;
  - `CtrlState` <= 0.
- State machine transitions depend only on the current inputs, never on the previous state. Any state may go to any state. `CtrlState` exists for observability only.
- PC arithmetic is modulo 2^32: `32'hFFFF_FFFC` + 4 = `32'h0000_0000`, with no error flag.
- `BranchTarget` low two bits are always discarded. A misaligned target never reaches `PC`.
- A held bubble stays a bubble: HOLD after SQUASH keeps `IF_ID_Valid`=0.

## Timing
- Async reset, effective immediately while `reset`=1, regardless of `clk`:
  - `PC`=`RESET_PC`;
  - `IF_ID_Instruction`=`NOP_INSTR`;
  - `IF_ID_PCPlus4`=0;
  - `IF_ID_Valid`=0;
  - `CtrlState`=0;
  - `StallCycles`=0;
  - `FlushCount`=0.
- First rising edge after reset deassertion with `Stall`=0 and `Flush`=1 fetches from `RESET_PC` into IF/ID.
- Latency: instruction at `PC` appears on `IF_ID_Instruction` one edge later. Redirect takes effect on `PC` one edge after `Flush`=0 is sampled, with exactly one bubble.
- All outputs are registered. `Stall`, `Flush`, `BranchTarget` and `Instruction` must be stable by the rising edge. No combinational input-to-output path.
- Reset asserted mid-stall or mid-squash overrides all in-flight activity. No pending action survives reset.

## Configuration
- Macro: `IF_ID_PERF_COUNTERS_EN`.
- Defined:
  - `StallCycles` increments on every HOLD edge;
  - `FlushCount` increments on every SQUASH edge;
  - both saturate at `32'hFFFF_FFFF`;
  - both clear only on reset.
- Undefined: both outputs are constant 0 and no counter registers are synthesized. All other behaviour is identical.

## Test plan
- **Reset then run:** release reset, `Instruction`=`32'h2008_0005`, `Stall`=0, `Flush`=1 for 3 edges.
  - After edge 1: `IF_ID_Instruction`=`32'h2008_0005`, `IF_ID_PCPlus4`=`32'h0040_0004`, `IF_ID_Valid`=1.
  - After edge 3: `PC`=`32'h0040_000C`.
- **Load-use stall:** `Stall`=1 for 2 edges at `PC`=`32'h0040_0010`. `PC` and IF_ID_* unchanged, `CtrlState`=1. With the macro, `StallCycles`=2.
- **Taken branch:** `Flush`=0, `BranchTarget`=`32'h0040_0103`.
  - `PC`=`32'h0040_0100`, `IF_ID_Instruction`=0, `IF_ID_Valid`=0, `CtrlState`=2.
  - Next RUN edge: `IF_ID_Valid`=1, `IF_ID_PCPlus4`=`32'h0040_0104`.
- **Simultaneous:** `Stall`=1 and `Flush`=0 on the same edge. Squash wins: `PC`=target, `FlushCount` +1, `StallCycles` unchanged.
- **Wrap:** force `PC`=`32'hFFFF_FFFC` via `BranchTarget`, then one RUN edge. `PC`=0, `IF_ID_PCPlus4`=0.
- **Async reset mid-stall:** assert `reset` between edges while `Stall`=1. All outputs reach reset values before the next edge.

Source files
------------

// File: rtl/if_id_pipe_ctrl.sv
// Fetch-side PC and IF/ID register controller applying hazard-unit Stall/Flush decisions.
// Optional hazard statistics counters enabled by IF_ID_PERF_COUNTERS_EN.
module if_id_pipe_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid,
   output logic [1:0]  CtrlState,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCount
);

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StHold   = 2'd1,
      StSquash = 2'd2
   } ctrl_state_e;

   ctrl_state_e state;
   logic [31:0] pc_plus4;
   logic        unused_bt_low;

   // Redirects are word-aligned; the low target bits never reach PC.
   assign unused_bt_low = ^BranchTarget[1:0];
   assign pc_plus4      = PC + 32'd4;
   assign CtrlState     = state;

   // Flush is active-low and outranks Stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PC                <= RESET_PC;
         IF_ID_Instruction <= NOP_INSTR;
         IF_ID_PCPlus4     <= 32'd0;
         IF_ID_Valid       <= 1'b0;
         state             <= StRun;
      end else if (!Flush) begin
         PC                <= {BranchTarget[31:2], 2'b00};
         IF_ID_Instruction <= NOP_INSTR;
         IF_ID_PCPlus4     <= 32'd0;
         IF_ID_Valid       <= 1'b0;
         state             <= StSquash;
      end else if (Stall) begin
         state <= StHold;
      end else begin
         PC                <= pc_plus4;
         IF_ID_Instruction <= Instruction;
         IF_ID_PCPlus4     <= pc_plus4;
         IF_ID_Valid       <= 1'b1;
         state             <= StRun;
      end
   end

`ifdef IF_ID_PERF_COUNTERS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         StallCycles <= 32'd0;
         FlushCount  <= 32'd0;
      end else if (!Flush) begin
         if (FlushCount != 32'hFFFF_FFFF) FlushCount <= FlushCount + 32'd1;
      end else if (Stall) begin
         if (StallCycles != 32'hFFFF_FFFF) StallCycles <= StallCycles + 32'd1;
      end
   end
`else
   assign StallCycles = 32'd0;
   assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// Directed, scoreboard-driven bench for if_id_pipe_ctrl (reset, run, stall, squash, wrap, async reset).
module tb_if_id_pipe_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h0040_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        Stall;
   logic        Flush;
   logic [31:0] BranchTarget;
   logic [31:0] Instruction;
   logic [31:0] PC;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic [1:0]  CtrlState;
   logic [31:0] StallCycles;
   logic [31:0] FlushCount;

   if_id_pipe_ctrl #(
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .Stall            (Stall),
      .Flush            (Flush),
      .BranchTarget     (BranchTarget),
      .Instruction      (Instruction),
      .PC               (PC),
      .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_PCPlus4    (IF_ID_PCPlus4),
      .IF_ID_Valid      (IF_ID_Valid),
      .CtrlState        (CtrlState),
      .StallCycles      (StallCycles),
      .FlushCount       (FlushCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] p4;
      logic        v;
      logic [1:0]  st;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   logic [31:0] m_pc, m_ins, m_p4, m_sc, m_fc;
   logic        m_v;
   logic [1:0]  m_st;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_ins = NOP_INSTR; m_p4 = 32'd0; m_v = 1'b0;
      m_st = 2'd0; m_sc = 32'd0; m_fc = 32'd0;
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.pc = m_pc; e.ins = m_ins; e.p4 = m_p4; e.v = m_v; e.st = m_st;
`ifdef IF_ID_PERF_COUNTERS_EN
      e.sc = m_sc; e.fc = m_fc;
`else
      e.sc = 32'd0; e.fc = 32'd0;
`endif
      return e;
   endfunction

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, ".PC"}, PC, e.pc);
      chk({tag, ".Instr"}, IF_ID_Instruction, e.ins);
      chk({tag, ".PCPlus4"}, IF_ID_PCPlus4, e.p4);
      chk({tag, ".Valid"}, {31'd0, IF_ID_Valid}, {31'd0, e.v});
      chk({tag, ".State"}, {30'd0, CtrlState}, {30'd0, e.st});
      chk({tag, ".StallCycles"}, StallCycles, e.sc);
      chk({tag, ".FlushCount"}, FlushCount, e.fc);
   endtask

   // Drive one edge worth of inputs, predict, then compare #1 after the edge.
   task automatic step(input string tag, input logic s, input logic f,
                       input logic [31:0] bt, input logic [31:0] ins);
      exp_t e;
      Stall = s; Flush = f; BranchTarget = bt; Instruction = ins;
      if (!f) begin
         m_pc = bt & 32'hFFFF_FFFC; m_ins = NOP_INSTR; m_p4 = 32'd0; m_v = 1'b0; m_st = 2'd2;
         if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end else if (s) begin
         m_st = 2'd1;
         if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else begin
         m_ins = ins; m_p4 = m_pc + 4; m_pc = m_pc + 4; m_v = 1'b1; m_st = 2'd0;
      end
      sb.push_back(snap());
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_all(tag, e);
   endtask

   initial begin
      logic [31:0] sc_before;
      reset = 1'b1; Stall = 1'b0; Flush = 1'b1; BranchTarget = 32'd0; Instruction = 32'd0;
      model_reset();
      #1;
      check_all("reset", snap());
      @(negedge clk);
      reset = 1'b0;

      // Reset then run
      step("run1", 1'b0, 1'b1, 32'd0, 32'h2008_0005);
      chk("run1.lit_instr", IF_ID_Instruction, 32'h2008_0005);
      chk("run1.lit_p4", IF_ID_PCPlus4, 32'h0040_0004);
      step("run2", 1'b0, 1'b1, 32'd0, 32'h2008_0005);
      step("run3", 1'b0, 1'b1, 32'd0, 32'h2008_0005);
      chk("run3.lit_pc", PC, 32'h0040_000C);
      step("run4", 1'b0, 1'b1, 32'd0, 32'h8C09_0000);
      chk("run4.lit_pc", PC, 32'h0040_0010);

      // Load-use stall, instruction input changes but must not be captured
      step("stall1", 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
      step("stall2", 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
      chk("stall.lit_pc", PC, 32'h0040_0010);
      chk("stall.lit_instr", IF_ID_Instruction, 32'h8C09_0000);
`ifdef IF_ID_PERF_COUNTERS_EN
      chk("stall.lit_cnt", StallCycles, 32'd2);
`endif

      // Taken branch with misaligned target, held bubble, then run
      step("br", 1'b0, 1'b0, 32'h0040_0103, 32'h1111_1111);
      chk("br.lit_pc", PC, 32'h0040_0100);
      step("br_hold", 1'b1, 1'b1, 32'd0, 32'h2222_2222);
      chk("br_hold.lit_valid", {31'd0, IF_ID_Valid}, 32'd0);
      step("br_run", 1'b0, 1'b1, 32'd0, 32'h3333_3333);
      chk("br_run.lit_p4", IF_ID_PCPlus4, 32'h0040_0104);

      // Simultaneous stall and flush: squash wins
      sc_before = StallCycles;
      step("simul", 1'b1, 1'b0, 32'h0040_0200, 32'h4444_4444);
      chk("simul.lit_pc", PC, 32'h0040_0200);
      chk("simul.lit_sc", StallCycles, sc_before);

      // Wrap around
      step("wrap_br", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0);
      chk("wrap_br.lit_pc", PC, 32'hFFFF_FFFC);
      step("wrap_run", 1'b0, 1'b1, 32'd0, 32'h5555_5555);
      chk("wrap_run.lit_pc", PC, 32'h0000_0000);
      chk("wrap_run.lit_p4", IF_ID_PCPlus4, 32'h0000_0000);
      step("post_wrap", 1'b0, 1'b1, 32'd0, 32'h6666_6666);

      // Async reset mid-stall, checked before the next edge
      step("pre_rst_stall", 1'b1, 1'b1, 32'd0, 32'h7777_7777);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst", snap());
      @(negedge clk);
      reset = 1'b0;
      step("after_rst", 1'b0, 1'b1, 32'd0, 32'h2008_0005);
      chk("after_rst.lit_p4", IF_ID_PCPlus4, 32'h0040_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
